// File: rtl/mc6845_bus_master.sv
// Host-side MC6845 CPU-port sequencer: turns one valid/ready register request
// into an address-register write (RS=0) followed by a data-register write or read (RS=1).
// Latency: 2*(E_HIGH+E_LOW)+1 cycles accept->rsp_valid, E_HIGH+E_LOW+1 on an address-cache hit.
// Backpressure: req_ready is high only in IDLE; one transaction in flight, no response backpressure.
//
// Ports:
//   CLK, RSTn                   clock, async active-low reset
//   req_valid/req_ready         request handshake; req_rw (1=read), req_addr, req_wdata captured on accept
//   rsp_valid, rsp_rdata        one-cycle completion pulse; read data held until the next read
//   CSn, E, RS, RW, D           MC6845 CPU bus pins (D driven only while writing)
module mc6845_bus_master #(
  parameter int E_HIGH     = 4,
  parameter int E_LOW      = 4,
  parameter bit ADDR_CACHE = 1'b0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CSn,
  output logic       E,
  output logic       RS,
  output logic       RW,
  inout  wire  [7:0] D
);

  localparam int PMAX = (E_HIGH > E_LOW) ? E_HIGH : E_LOW;
  localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [CW-1:0] HI_LOAD = CW'(E_HIGH - 1);
  localparam logic [CW-1:0] LO_LOAD = CW'(E_LOW - 1);

  typedef enum logic [2:0] {IDLE, A_HI, A_LO, D_HI, D_LO, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          rw_q;
  logic [4:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [4:0]    last_addr;
  logic          last_valid;
  logic          cache_hit;
  logic          phase_end;
  logic          d_oe;
  logic [7:0]    d_out;

  // Compared against the live request, since the capture registers load on the same edge.
  assign cache_hit = ADDR_CACHE && last_valid && (req_addr == last_addr);
  assign phase_end = (cnt == '0);

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = cache_hit ? D_HI : A_HI;
      A_HI:    if (phase_end) state_nxt = A_LO;
      A_LO:    if (phase_end) state_nxt = D_HI;
      D_HI:    if (phase_end) state_nxt = D_LO;
      D_LO:    if (phase_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter: reloaded on every state change with the length of the
  // phase being entered, then counts down to zero inside the phase.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        A_HI, D_HI: cnt <= HI_LOAD;
        A_LO, D_LO: cnt <= LO_LOAD;
        default:    cnt <= '0;
      endcase
    end else if (!phase_end) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Request capture, address cache and read-data capture
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rw_q       <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        rw_q    <= req_rw;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // The cache only counts an address once its full phase has completed.
      if (state == A_LO && phase_end) begin
        last_addr  <= addr_q;
        last_valid <= 1'b1;
      end
      // Sample on the edge where E falls, i.e. the end of the last D_HI cycle.
      if (state == D_HI && phase_end && rw_q) begin
        rsp_rdata <= D;
      end
    end
  end

  // Output decode: pins are pure functions of state so an async reset
  // releases the bus in the same cycle.
  always_comb begin
    CSn       = 1'b1;
    E         = 1'b0;
    RS        = 1'b0;
    RW        = 1'b1;
    d_oe      = 1'b0;
    d_out     = '0;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      A_HI, A_LO: begin
        CSn   = 1'b0;
        E     = (state == A_HI);
        RW    = 1'b0;
        d_oe  = 1'b1;
        d_out = {3'b000, addr_q};
      end
      D_HI, D_LO: begin
        CSn   = 1'b0;
        E     = (state == D_HI);
        RS    = 1'b1;
        RW    = rw_q;
        d_oe  = !rw_q;
        d_out = wdata_q;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign D = d_oe ? d_out : 8'bz;

endmodule

// File: tb/tb_mc6845_bus_master.sv
// Bench for mc6845_bus_master: three instances (4/4 no cache, 4/4 cache, 1/1 cache)
// each driven by a request queue; an expected pin waveform is generated per accepted
// request and compared every cycle, with literal latency/read-data pins on chosen requests.
module tb_mc6845_bus_master;

  typedef struct {
    logic       rw;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         gap;
    int         pin_lat;
    int         pin_rd;
    bit         rst_dhi;
  } req_t;

  typedef struct {
    logic       csn, e, rs, rw, drv, rsp, rdy;
    logic [7:0] d;
    logic [7:0] rdata;
    bit         rst_here;
  } cyc_t;

  typedef struct {
    int acc;
    int pin_lat;
    int pin_rd;
  } meta_t;

  logic clk;
  int   n_total = 0;
  int   n_bad   = 0;
  bit   done_f [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", nm, g, act, exp);
    end
  endtask

  function automatic req_t mk(input logic rw, input logic [4:0] a, input logic [7:0] w,
                              input int gap, input int pl, input int pr, input bit rst);
    req_t r;
    r.rw = rw; r.addr = a; r.wdata = w; r.gap = gap;
    r.pin_lat = pl; r.pin_rd = pr; r.rst_dhi = rst;
    return r;
  endfunction

  function automatic cyc_t mkc(input logic csn, input logic e, input logic rs, input logic rw,
                               input logic drv, input logic [7:0] dv, input logic rsp,
                               input logic rdy, input logic [7:0] rd, input bit rh);
    cyc_t c;
    c.csn = csn; c.e = e; c.rs = rs; c.rw = rw; c.drv = drv; c.d = dv;
    c.rsp = rsp; c.rdy = rdy; c.rdata = rd; c.rst_here = rh;
    return c;
  endfunction

  // Idle bus: deselected, nobody but the bench's bus model drives D.
  function automatic cyc_t idle(input logic [7:0] rd);
    return mkc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1, rd, 1'b0);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int P_EH = (g == 2) ? 1 : 4;
    localparam int P_EL = (g == 2) ? 1 : 4;
    localparam bit P_AC = (g != 0);

    logic       rst_n, req_valid, req_ready, req_rw, rsp_valid;
    logic [4:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;
    logic       csn, e, rs, rw;
    wire  [7:0] d;
    logic       tb_oe;
    logic [7:0] tb_val;

    // Bench-side bus: drives D whenever the DUT must have released it.
    assign d = tb_oe ? tb_val : 8'bz;

    mc6845_bus_master #(.E_HIGH(P_EH), .E_LOW(P_EL), .ADDR_CACHE(P_AC)) dut (
      .CLK(clk), .RSTn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .CSn(csn), .E(e), .RS(rs), .RW(rw), .D(d)
    );

    req_t  rq[$];
    cyc_t  exp_q[$];
    meta_t mq[$];

    initial begin : run
      cyc_t       cur;
      req_t       r;
      meta_t      m;
      logic       lv, hit;
      logic [4:0] la;
      logic [7:0] last_rd, rdv, rd_now;
      int         cyc, gapc, n_acc, n_rsp, n_abort;
      bit         acc;

      if (g == 0) begin
        rq.push_back(mk(1'b0, 5'h0E, 8'hFA, 0, 17, -1, 1'b0));
        rq.push_back(mk(1'b1, 5'h0F, 8'h00, 2, 17, 'hAD, 1'b0));
        rq.push_back(mk(1'b0, 5'h03, 8'h11, 0, 17, -1, 1'b0));
        rq.push_back(mk(1'b1, 5'h04, 8'h00, 0, 17, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h05, 8'h22, 0, 17, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h1F, 8'h9C, 1, 17, -1, 1'b0));
      end else if (g == 1) begin
        rq.push_back(mk(1'b0, 5'h01, 8'h4C, 0, 17, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h01, 8'h50, 0, 9, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h02, 8'h77, 0, 17, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h07, 8'h11, 1, 17, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h07, 8'h22, 1, -1, -1, 1'b1));
        rq.push_back(mk(1'b0, 5'h07, 8'h33, 1, 17, -1, 1'b0));
        rq.push_back(mk(1'b1, 5'h07, 8'h00, 0, 9, -1, 1'b0));
        rq.push_back(mk(1'b0, 5'h07, 8'h44, 0, 9, -1, 1'b0));
      end else begin
        rq.push_back(mk(1'b0, 5'h00, 8'h5E, 0, 5, -1, 1'b0));
        rq.push_back(mk(1'b1, 5'h0F, 8'h00, 0, 5, 'hAD, 1'b0));
      end
      for (int i = 0; i < 25; i++) begin
        rq.push_back(mk(1'($urandom_range(0, 1)),
                        5'((g == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3)),
                        8'($urandom), int'($urandom_range(0, 3)), -1, -1, 1'b0));
      end

      lv = 1'b0; la = '0; last_rd = '0;
      cyc = 0; gapc = -1; n_acc = 0; n_rsp = 0; n_abort = 0;
      req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
      tb_oe = 1'b1; tb_val = 8'hC3;
      cur = idle(8'h00);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pins", g, 64'({csn, e, rs, rw, rsp_valid}), 64'(5'b10010));
      chk("reset_rdata", g, 64'(rsp_rdata), 64'(8'h00));
      chk("reset_d_released", g, 64'(d), 64'(8'hC3));
      rst_n = 1'b1;

      while ((rq.size() > 0 || exp_q.size() > 0 || req_valid) && cyc < 4000) begin
        @(posedge clk);
        cyc++;
        acc = req_valid && cur.rdy;
        if (acc) begin
          r = rq.pop_front();
          gapc = -1;
          n_acc++;
          m.acc = cyc - 1; m.pin_lat = r.pin_lat; m.pin_rd = r.pin_rd;
          mq.push_back(m);
          hit    = P_AC && lv && (r.addr == la);
          rdv    = (r.addr == 5'h0F) ? 8'hAD : 8'($urandom);
          rd_now = last_rd;
          if (!hit) begin
            for (int i = 0; i < P_EH; i++)
              exp_q.push_back(mkc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {3'b000, r.addr}, 1'b0, 1'b0, rd_now, 1'b0));
            for (int i = 0; i < P_EL; i++)
              exp_q.push_back(mkc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {3'b000, r.addr}, 1'b0, 1'b0, rd_now, 1'b0));
            lv = 1'b1;
            la = r.addr;
          end
          for (int i = 0; i < P_EH; i++)
            exp_q.push_back(mkc(1'b0, 1'b1, 1'b1, r.rw, !r.rw, r.rw ? rdv : r.wdata,
                                1'b0, 1'b0, rd_now, (i == 0) && r.rst_dhi));
          if (r.rw) rd_now = rdv;
          for (int i = 0; i < P_EL; i++)
            exp_q.push_back(mkc(1'b0, 1'b0, 1'b1, r.rw, !r.rw, r.rw ? 8'($urandom) : r.wdata,
                                1'b0, 1'b0, rd_now, 1'b0));
          exp_q.push_back(mkc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0, rd_now, 1'b0));
        end
        #1;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  cur = idle(last_rd);
        last_rd = cur.rdata;
        tb_oe   = !cur.drv;
        tb_val  = cur.d;
        #1;
        chk($sformatf("cycle%0d", cyc), g,
            64'({csn, e, rs, rw, rsp_valid, req_ready, d, rsp_rdata}),
            64'({cur.csn, cur.e, cur.rs, cur.rw, cur.rsp, cur.rdy, cur.d, cur.rdata}));
        if (rsp_valid) begin
          n_rsp++;
          if (mq.size() == 0) begin
            chk("spurious_rsp", g, 64'(rsp_valid), 64'(1'b0));
          end else begin
            m = mq.pop_front();
            if (m.pin_lat >= 0) chk("latency", g, 64'(cyc - m.acc), 64'(m.pin_lat));
            if (m.pin_rd >= 0)  chk("read_data", g, 64'(rsp_rdata), 64'(m.pin_rd));
          end
        end
        if (cur.rst_here) begin
          rst_n = 1'b0;
          req_valid = 1'b0;
          exp_q.delete();
          mq.delete();
          n_abort++;
          lv = 1'b0;
          last_rd = '0;
          tb_oe = 1'b1;
          tb_val = 8'h96;
          #1;
          chk("abort_pins", g, 64'({csn, e, rsp_valid}), 64'(3'b100));
          chk("abort_d_released", g, 64'(d), 64'(8'h96));
          chk("abort_rdata", g, 64'(rsp_rdata), 64'(8'h00));
          cur = idle(8'h00);
          @(posedge clk);
          cyc++;
          #2 rst_n = 1'b1;
        end
        if (acc) req_valid = 1'b0;
        if (rq.size() > 0) begin
          if (!req_valid) begin
            if (gapc < 0) gapc = rq[0].gap;
            if (gapc > 0) begin
              gapc--;
              req_rw    = 1'($urandom);
              req_addr  = 5'($urandom);
              req_wdata = 8'($urandom);
            end else begin
              req_valid = 1'b1;
              req_rw    = rq[0].rw;
              req_addr  = rq[0].addr;
              req_wdata = rq[0].wdata;
            end
          end
        end else begin
          req_valid = 1'b0;
        end
      end

      chk("within_budget", g, 64'(cyc < 4000), 64'(1'b1));
      chk("rsp_count", g, 64'(n_rsp), 64'(n_acc - n_abort));
      chk("no_pending_rsp", g, 64'(mq.size()), 64'(0));
      done_f[g] = 1'b1;
    end
  end

  initial begin : summary
    int k;
    k = 0;
    while (!(done_f[0] && done_f[1] && done_f[2]) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk("all_instances_done", -1, 64'(k < 20000), 64'(1'b1));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
